// File: rtl/cci_mpf_prim_distrib_rr.sv
// cci_mpf_prim_distrib_rr: one-to-many round-robin distributor feeding per-client FWFT FIFOs
module cci_mpf_prim_distrib_rr #(
  parameter int NUM_CLIENTS = 4,
  parameter int DATA_WIDTH  = 64,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  input  logic [DATA_WIDTH-1:0]             in_data,
  output logic                              in_ready,
  output logic [$clog2(NUM_CLIENTS)-1:0]    in_client,
  output logic [NUM_CLIENTS-1:0]            out_valid,
  output logic [NUM_CLIENTS*DATA_WIDTH-1:0] out_data,
  input  logic [NUM_CLIENTS-1:0]            out_deq
);
  localparam int CW = $clog2(NUM_CLIENTS);
  localparam int PW = $clog2(FIFO_DEPTH);
  logic [NUM_CLIENTS-1:0] base, full, avail, grant;
  logic [2*NUM_CLIENTS-1:0] dbl, dbl_grant;
  logic accept;
  assign avail = ~full;
  assign dbl = {avail, avail};
  assign dbl_grant = dbl & ~(dbl - {{NUM_CLIENTS{1'b0}}, base});
  assign grant = dbl_grant[NUM_CLIENTS-1:0] | dbl_grant[2*NUM_CLIENTS-1:NUM_CLIENTS];
  assign in_ready = ~reset & |avail;
  assign accept = in_valid & in_ready;
  // binary index of the one-hot winner
  always_comb begin
    in_client = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) in_client = grant[i] ? CW'(i) : in_client;
  end
  // priority moves to the client after the winner on every accept
  always_ff @(posedge clk) begin
    if (reset) base <= NUM_CLIENTS'(1);
    else if (accept) base <= {grant[NUM_CLIENTS-2:0], grant[NUM_CLIENTS-1]};
  end
  for (genvar g = 0; g < NUM_CLIENTS; g++) begin : g_fifo
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0] count;
    logic enq, deq;
    assign enq = accept & grant[g];
    assign deq = out_deq[g] & out_valid[g];
    assign full[g] = count == (PW+1)'(FIFO_DEPTH);
    assign out_valid[g] = count != '0;
    assign out_data[g*DATA_WIDTH +: DATA_WIDTH] = mem[rd_ptr];
    // storage is left unreset; out_data is only meaningful while out_valid
    always_ff @(posedge clk) begin
      if (enq) mem[wr_ptr] <= in_data;
    end
    // pointers wrap naturally since depth is a power of two
    always_ff @(posedge clk) begin
      if (reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        wr_ptr <= wr_ptr + PW'(enq);
        rd_ptr <= rd_ptr + PW'(deq);
        count  <= count + (PW+1)'(enq) - (PW+1)'(deq);
      end
    end
`ifndef SYNTHESIS
    a_deq_empty: assert property (@(posedge clk) disable iff (reset) !(out_deq[g] && !out_valid[g]));
`endif
  end
endmodule
